// File: rtl/gesture_uart_framer.sv
// Gesture result framer: buffers classifier results in a small FIFO and
// streams each one as a 5-byte packet (header, class, conf, seq, xor)
// into an 8N1 UART transmitter through its data/valid/busy interface.
//
// Handshake: a result is taken on any cycle with res_valid=1 and room in
// the FIFO (res_ready=1, or a pop in the same cycle); otherwise it is
// dropped and counted. Toward the UART, tx_valid is a one-cycle strobe
// issued only while tx_busy=0; tx_data is stable from that strobe until
// tx_busy falls again.
module gesture_uart_framer #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         CLASS_W    = 2,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               res_valid,
    input  logic [CLASS_W-1:0] res_class,
    input  logic [7:0]         res_conf,
    output logic               res_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_busy,
    output logic               pkt_active,
    output logic [7:0]         drop_cnt,
    output logic [2:0]         dbg_state
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [CLASS_W-1:0] fifo_class [FIFO_DEPTH];
    logic [7:0]         fifo_conf  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               full, empty, push, pop, drop;

    logic [7:0]         pkt_class, pkt_conf, seq;
    logic [2:0]         byte_idx;
    logic               wait_cnt;
    logic [7:0]         cur_byte;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign res_ready = !full;
    assign pop       = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees the slot the new result lands in.
    assign push      = res_valid && (!full || pop);
    assign drop      = res_valid && full && !pop;
    assign dbg_state = state;

    // FIFO storage: written on push, no reset needed for the payload.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_class[wr_ptr] <= res_class;
            fifo_conf[wr_ptr]  <= res_conf;
        end
    end

    // FIFO pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Byte selector for the packet currently being sent.
    always_comb begin
        cur_byte = pkt_class ^ pkt_conf ^ seq;
        case (byte_idx)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = pkt_class;
            3'd2:    cur_byte = pkt_conf;
            3'd3:    cur_byte = seq;
            default: cur_byte = pkt_class ^ pkt_conf ^ seq;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state and strobe/activity outputs.
    always_comb begin
        state_nx   = state;
        tx_valid   = 1'b0;
        pkt_active = 1'b1;
        case (state)
            S_IDLE: begin
                pkt_active = 1'b0;
                if (!empty) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (!tx_busy) state_nx = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                state_nx = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // Two cycles without busy means the strobe was missed: resend.
                if (tx_busy)       state_nx = S_WAIT_LO;
                else if (wait_cnt) state_nx = S_LOAD;
            end
            S_WAIT_LO: begin
                if (!tx_busy) state_nx = (byte_idx == 3'd4) ? S_IDLE : S_LOAD;
            end
            default: begin
                pkt_active = 1'b0;
                state_nx   = S_IDLE;
            end
        endcase
    end

    // Packet datapath: latch popped result, drive tx_data, step byte/seq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_class <= 8'd0;
            pkt_conf  <= 8'd0;
            seq       <= 8'd0;
            byte_idx  <= 3'd0;
            wait_cnt  <= 1'b0;
            tx_data   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        pkt_class <= 8'(fifo_class[rd_ptr]);
                        pkt_conf  <= fifo_conf[rd_ptr];
                        byte_idx  <= 3'd0;
                    end
                end
                S_LOAD:    tx_data  <= cur_byte;
                S_SEND:    wait_cnt <= 1'b0;
                S_WAIT_HI: if (!tx_busy) wait_cnt <= 1'b1;
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byte_idx == 3'd4) seq <= seq + 8'd1;
                        else                  byte_idx <= byte_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
